tex_cache_refill_ctrl: RTL and testbench
========================================

TEX_CACHE_REFILL_CTRL -- requirements
Module: tex_cache_refill_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: idle cycles after each cache write, covering the cache's 1-cycle lookup latency; legal range 1..7.
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_nrst  input  1  synchronous active-low reset.
REQ-005 i_missA, i_missB  input  1 each  miss flags from texture cache ports A/B.
REQ-006 i_adressLookA, i_adressLookB  input  19 each  halfword lookup addresses; bits [18:2] form the 64-bit word address.
REQ-007 o_memReq  output  1  memory read request.
REQ-008 o_memAddr  output  17  requested 64-bit word address.
REQ-009 i_memAck  input  1  memory accepted the request.
REQ-010 i_memDataValid, i_memData  input  1/64  read data return.
REQ-011 o_cacheWrite, o_cacheAddr, o_cacheData  output  1/17/64  cache fill write port.
REQ-012 o_busy  output  1  high in every state except IDLE.
REQ-013 o_doneA, o_doneB  output  1 each  1-cycle pulse when that port's word has been written.

Function
REQ-014 States: IDLE, REQ, WAIT_DATA, WRITE, SETTLE.
REQ-015 IDLE: on any miss, grant one port, latch address[18:2] into o_memAddr, latch serveA/serveB, then go to REQ the next cycle.
REQ-016 Both misses in the same cycle with equal [18:2]: serve both with one fetch; the round-robin pointer is unchanged.
REQ-017 Both misses with different words: grant the port opposite lastGrant, then update lastGrant. A single miss is granted directly and sets lastGrant.
REQ-018 REQ: o_memReq=1 with o_memAddr stable until i_memAck is sampled high.
  - Ack with data valid in the same cycle: capture data, go to WRITE.
  - Ack without data: go to WAIT_DATA.
REQ-019 WAIT_DATA: on i_memDataValid, capture i_memData into a register and go to WRITE. i_memDataValid in any other state SHALL be ignored.
REQ-020 WRITE: one cycle with o_cacheWrite=1, o_cacheAddr=latched address, o_cacheData=captured data. Pulse o_doneA/o_doneB for the served port(s) in the same cycle.
REQ-021 SETTLE: hold for exactly SETTLE_CYCLES cycles, ignoring misses, then go to IDLE.
REQ-022 Latency, single miss with immediate ack+data: miss sampled at cycle N, o_memReq at N+1, o_cacheWrite at N+2, IDLE at N+2+SETTLE_CYCLES+1.
REQ-023 A port not served keeps its sticky miss and is granted at the next IDLE; no request is lost.
REQ-024 Request addresses SHALL NOT change between grant and WRITE, even if lookup inputs change.

Reset
REQ-025 i_nrst=0 forces IDLE and lastGrant=B (so A wins the first tie).
REQ-026 i_nrst=0 drives all outputs and data/address registers to 0.
REQ-027 Reset mid-transaction abandons the fetch. Late i_memAck or i_memDataValid after reset causes no cache write.

Structure
REQ-028 State encoding and the 17-bit word-address width SHALL live in the shared GPU package.
REQ-029 Single module; no sub-module (the arbiter is a few gates).

Verification
REQ-030 Single miss A at address 0x1234C, ack+data same cycle, data 0xDEADBEEF_CAFEF00D -> o_memAddr=0x048D3; o_cacheWrite exactly 1 cycle with that address/data; o_doneA pulse; o_doneB=0.
REQ-031 Simultaneous misses A=0x00010, B=0x00020 -> A fetched first (addr 0x00004), then B (addr 0x00008); exactly two writes; repeating the tie grants B first.
REQ-032 Simultaneous misses, both addresses 0x7FFF8 -> one fetch (addr 0x1FFFE); one write; o_doneA and o_doneB pulse together.
REQ-033 Ack held low 5 cycles, data 3 cycles after ack -> o_memReq high 6 cycles with stable address; write one cycle after data valid.
REQ-034 Reset asserted in WAIT_DATA, data arrives 2 cycles later -> no o_cacheWrite; o_busy=0; next miss serviced normally.
REQ-035 Miss held through SETTLE with SETTLE_CYCLES=3 -> no new o_memReq until 3 settle cycles elapse.

Source files
------------

// File: rtl/tex_cache_refill_ctrl_pkg.sv
// Shared GPU definitions for the texture cache refill path: FSM encoding and
// the 64-bit word address width.
package tex_cache_refill_ctrl_pkg;

  localparam int WORD_ADDR_W = 17;
  localparam int STATE_W     = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_DATA = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd4;

  typedef logic [WORD_ADDR_W-1:0] wordAddr_t;

endpackage

// File: rtl/tex_cache_refill_ctrl.sv
// Texture cache refill controller: arbitrates misses from ports A/B, fetches one
// 64-bit word from memory, writes it into the cache and waits out the lookup latency.
module tex_cache_refill_ctrl
  import tex_cache_refill_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_missA,
  input  logic        i_missB,
  input  logic [18:0] i_adressLookA,
  input  logic [18:0] i_adressLookB,
  output logic        o_memReq,
  output logic [16:0] o_memAddr,
  input  logic        i_memAck,
  input  logic        i_memDataValid,
  input  logic [63:0] i_memData,
  output logic        o_cacheWrite,
  output logic [16:0] o_cacheAddr,
  output logic [63:0] o_cacheData,
  output logic        o_busy,
  output logic        o_doneA,
  output logic        o_doneB
);

  logic [STATE_W-1:0] state;
  wordAddr_t          addrReg;
  logic [63:0]        dataReg;
  logic               serveA, serveB;
  logic               lastGrantB;
  logic               pendA, pendB;
  wordAddr_t          pendAddrA, pendAddrB;
  logic [2:0]         settleCnt;

  // Halfword offset bits never take part in word selection.
  logic unusedLowBits;
  assign unusedLowBits = ^{i_adressLookA[1:0], i_adressLookB[1:0]};

  logic      wantA, wantB, sameWord;
  wordAddr_t wAddrA, wAddrB;
  logic      grantA, grantB, deferA, deferB, updLast, nextLastB;

  // A deferred port is served from its captured address, not the live lookup bus.
  assign wantA    = i_missA | pendA;
  assign wantB    = i_missB | pendB;
  assign wAddrA   = pendA ? pendAddrA : i_adressLookA[18:2];
  assign wAddrB   = pendB ? pendAddrB : i_adressLookB[18:2];
  assign sameWord = (wAddrA == wAddrB);

  always_comb begin
    grantA    = 1'b0;
    grantB    = 1'b0;
    deferA    = 1'b0;
    deferB    = 1'b0;
    updLast   = 1'b0;
    nextLastB = lastGrantB;
    if (wantA && wantB) begin
      if (sameWord) begin
        grantA = 1'b1;
        grantB = 1'b1;
      end else if (lastGrantB) begin
        grantA    = 1'b1;
        deferB    = 1'b1;
        updLast   = 1'b1;
        nextLastB = 1'b0;
      end else begin
        grantB    = 1'b1;
        deferA    = 1'b1;
        updLast   = 1'b1;
        nextLastB = 1'b1;
      end
    end else if (wantA) begin
      // Serving the loser of an earlier tie leaves the round-robin pointer alone.
      grantA    = 1'b1;
      updLast   = ~pendA;
      nextLastB = 1'b0;
    end else if (wantB) begin
      grantB    = 1'b1;
      updLast   = ~pendB;
      nextLastB = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state      <= ST_IDLE;
      addrReg    <= '0;
      dataReg    <= '0;
      serveA     <= 1'b0;
      serveB     <= 1'b0;
      lastGrantB <= 1'b1;
      pendA      <= 1'b0;
      pendB      <= 1'b0;
      pendAddrA  <= '0;
      pendAddrB  <= '0;
      settleCnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wantA || wantB) begin
            addrReg <= grantA ? wAddrA : wAddrB;
            serveA  <= grantA;
            serveB  <= grantB;
            pendA   <= deferA;
            pendB   <= deferB;
            if (deferA) pendAddrA <= wAddrA;
            if (deferB) pendAddrB <= wAddrB;
            if (updLast) lastGrantB <= nextLastB;
            state <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT_DATA: begin
          // New misses on the idle port are remembered so none is lost.
          if (i_missA && !serveA && !pendA) begin
            pendA     <= 1'b1;
            pendAddrA <= i_adressLookA[18:2];
          end
          if (i_missB && !serveB && !pendB) begin
            pendB     <= 1'b1;
            pendAddrB <= i_adressLookB[18:2];
          end
          if (state == ST_REQ) begin
            if (i_memAck) begin
              if (i_memDataValid) begin
                dataReg <= i_memData;
                state   <= ST_WRITE;
              end else begin
                state <= ST_WAIT_DATA;
              end
            end
          end else if (i_memDataValid) begin
            dataReg <= i_memData;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          settleCnt <= 3'(SETTLE_CYCLES - 1);
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settleCnt == 3'd0) state <= ST_IDLE;
          else settleCnt <= settleCnt - 3'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_memReq     = (state == ST_REQ);
  assign o_memAddr    = addrReg;
  assign o_cacheWrite = (state == ST_WRITE);
  assign o_cacheAddr  = addrReg;
  assign o_cacheData  = dataReg;
  assign o_busy       = (state != ST_IDLE);
  assign o_doneA      = o_cacheWrite & serveA;
  assign o_doneB      = o_cacheWrite & serveB;

endmodule

// File: tb/tb_tex_cache_refill_ctrl.sv
// Directed bench for tex_cache_refill_ctrl: a vector table of single-miss fetches
// plus hand-written sequences for ties, shared words, reset and settle timing.
module tb_tex_cache_refill_ctrl;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        missA = 1'b0, missB = 1'b0;
  logic [18:0] addrA = '0, addrB = '0;
  logic        memReq;
  logic [16:0] memAddr;
  logic        memAck = 1'b0;
  logic        memDataValid = 1'b0;
  logic [63:0] memData = '0;
  logic        cacheWrite;
  logic [16:0] cacheAddr;
  logic [63:0] cacheData;
  logic        busy, doneA, doneB;

  int checks = 0;
  int errors = 0;
  int writeCount = 0;

  always #5 clk = ~clk;

  tex_cache_refill_ctrl #(.SETTLE_CYCLES(S)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_missA(missA), .i_missB(missB),
    .i_adressLookA(addrA), .i_adressLookB(addrB),
    .o_memReq(memReq), .o_memAddr(memAddr),
    .i_memAck(memAck), .i_memDataValid(memDataValid), .i_memData(memData),
    .o_cacheWrite(cacheWrite), .o_cacheAddr(cacheAddr), .o_cacheData(cacheData),
    .o_busy(busy), .o_doneA(doneA), .o_doneB(doneB)
  );

  always @(negedge clk) if (cacheWrite) writeCount++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic        port;      // 0 = A, 1 = B
    logic [18:0] addr;
    logic [63:0] data;
    int          ackDly;
    int          dataDly;
    logic [16:0] expAddr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkW(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch from REQ through WRITE, SETTLE and back to IDLE.
  task automatic serveFetch(input logic [16:0] expAddr, input logic [63:0] data,
                            input int ackDly, input int dataDly,
                            input logic expDA, input logic expDB);
    int n = 0;
    while (!memReq && n < 20) begin
      tick();
      n++;
    end
    chk1("req_seen", memReq, 1'b1);
    for (int i = 0; i < ackDly; i++) begin
      chk1("req_hold", memReq, 1'b1);
      chkW("req_addr_hold", 64'(memAddr), 64'(expAddr));
      tick();
    end
    chk1("req_at_ack", memReq, 1'b1);
    chkW("req_addr", 64'(memAddr), 64'(expAddr));
    memAck = 1'b1;
    memDataValid = (dataDly == 0);
    memData = data;
    tick();
    memAck = 1'b0;
    memDataValid = 1'b0;
    if (dataDly > 0) begin
      chk1("req_drop", memReq, 1'b0);
      for (int i = 1; i < dataDly; i++) begin
        chk1("no_early_write", cacheWrite, 1'b0);
        tick();
      end
      memDataValid = 1'b1;
      memData = data;
      tick();
      memDataValid = 1'b0;
    end
    memData = '0;
    chk1("write", cacheWrite, 1'b1);
    chkW("write_addr", 64'(cacheAddr), 64'(expAddr));
    chkW("write_data", cacheData, data);
    chk1("doneA", doneA, expDA);
    chk1("doneB", doneB, expDB);
    tick();
    chk1("write_once", cacheWrite, 1'b0);
    chk1("done_clear", doneA | doneB, 1'b0);
    chk1("settle_busy", busy, 1'b1);
    for (int i = 1; i < S; i++) begin
      tick();
      chk1("settle_busy", busy, 1'b1);
      chk1("settle_noreq", memReq, 1'b0);
    end
    tick();
    chk1("back_idle", busy, 1'b0);
    $display("txn addr=%h data=%h doneA=%b doneB=%b", expAddr, data, expDA, expDB);
  endtask

  initial begin
    int w0;
    vecs[0] = '{1'b0, 19'h1234C, 64'hDEADBEEF_CAFEF00D, 0, 0, 17'h048D3};
    vecs[1] = '{1'b1, 19'h00004, 64'h0000_0000_0000_0001, 0, 1, 17'h00001};
    vecs[2] = '{1'b0, 19'h7FFFF, 64'h1234_5678_9ABC_DEF0, 1, 2, 17'h1FFFF};
    vecs[3] = '{1'b1, 19'h40002, 64'hA5A5_5A5A_0F0F_F0F0, 5, 3, 17'h10000};
    vecs[4] = '{1'b0, 19'h00003, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 17'h00000};

    // Reset state
    repeat (3) tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_memReq", memReq, 1'b0);
    chkW("rst_memAddr", 64'(memAddr), 64'h0);
    chk1("rst_cacheWrite", cacheWrite, 1'b0);
    chkW("rst_cacheAddr", 64'(cacheAddr), 64'h0);
    chkW("rst_cacheData", cacheData, 64'h0);
    chk1("rst_doneA", doneA, 1'b0);
    chk1("rst_doneB", doneB, 1'b0);
    nrst = 1'b1;
    tick();

    // Tie on different words: A first after reset, B first on the repeat
    w0 = writeCount;
    missA = 1'b1; addrA = 19'h00010;
    missB = 1'b1; addrB = 19'h00020;
    tick();
    missA = 1'b0; missB = 1'b0;
    serveFetch(17'h00004, 64'h1111_0000_0000_0001, 0, 0, 1'b1, 1'b0);
    serveFetch(17'h00008, 64'h2222_0000_0000_0002, 0, 0, 1'b0, 1'b1);
    repeat (3) tick();
    chkW("tie_writes", 64'(writeCount - w0), 64'd2);
    chk1("tie_idle", busy, 1'b0);
    missA = 1'b1; missB = 1'b1;
    tick();
    missA = 1'b0; missB = 1'b0;
    serveFetch(17'h00008, 64'h3333_0000_0000_0003, 0, 0, 1'b0, 1'b1);
    serveFetch(17'h00004, 64'h4444_0000_0000_0004, 0, 0, 1'b1, 1'b0);

    // Both ports miss on the same word: one fetch, both done
    repeat (2) tick();
    w0 = writeCount;
    missA = 1'b1; addrA = 19'h7FFF8;
    missB = 1'b1; addrB = 19'h7FFF8;
    tick();
    missA = 1'b0; missB = 1'b0;
    serveFetch(17'h1FFFE, 64'h5555_AAAA_5555_AAAA, 0, 0, 1'b1, 1'b1);
    repeat (3) tick();
    chk1("same_noreq", memReq, 1'b0);
    chkW("same_writes", 64'(writeCount - w0), 64'd1);

    // Data valid outside a fetch is ignored
    w0 = writeCount;
    memDataValid = 1'b1; memData = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    memDataValid = 1'b0; memData = '0;
    repeat (2) tick();
    chkW("stray_data_writes", 64'(writeCount - w0), 64'd0);
    chk1("stray_data_busy", busy, 1'b0);

    // Vector table: single misses with varied ack/data delays
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].port == 1'b0) begin
        missA = 1'b1; addrA = vecs[v].addr;
      end else begin
        missB = 1'b1; addrB = vecs[v].addr;
      end
      tick();
      missA = 1'b0; missB = 1'b0;
      // Lookup buses move on; the latched fetch address must not follow
      addrA = 19'h55555; addrB = 19'h2AAAA;
      chk1("lat_req", memReq, 1'b1);
      serveFetch(vecs[v].expAddr, vecs[v].data, vecs[v].ackDly, vecs[v].dataDly,
                 ~vecs[v].port, vecs[v].port);
    end

    // Reset in WAIT_DATA abandons the fetch
    missA = 1'b1; addrA = 19'h00100;
    tick();
    missA = 1'b0;
    chk1("rstx_req", memReq, 1'b1);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chk1("rstx_wait_busy", busy, 1'b1);
    chk1("rstx_wait_noreq", memReq, 1'b0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk1("rstx_busy", busy, 1'b0);
    chkW("rstx_memAddr", 64'(memAddr), 64'h0);
    w0 = writeCount;
    tick();
    memAck = 1'b1; memDataValid = 1'b1; memData = 64'hCAFE_CAFE_CAFE_CAFE;
    tick();
    memAck = 1'b0; memDataValid = 1'b0; memData = '0;
    repeat (3) tick();
    chkW("rstx_writes", 64'(writeCount - w0), 64'd0);
    chk1("rstx_idle", busy, 1'b0);
    chkW("rstx_data", cacheData, 64'h0);
    missB = 1'b1; addrB = 19'h00200;
    tick();
    missB = 1'b0;
    serveFetch(17'h00080, 64'h0BAD_F00D_0000_0042, 0, 0, 1'b0, 1'b1);

    // Miss held through SETTLE: no new request until the settle window ends
    missA = 1'b1; addrA = 19'h00400;
    tick();
    chk1("hold_req", memReq, 1'b1);
    serveFetch(17'h00100, 64'h0102_0304_0506_0708, 0, 0, 1'b1, 1'b0);
    tick();
    missA = 1'b0;
    chk1("hold_rereq", memReq, 1'b1);
    serveFetch(17'h00100, 64'h0807_0605_0403_0201, 0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
